mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_prio.sv | 49 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`timescale 1ns/1ps
// Shared types and default sizing for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  localparam int AW_DEF       = 16;
  localparam int DW_DEF       = 32;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_prio.sv
`timescale 1ns/1ps
// Winner select between fetch and data ports; data is favoured until a waiting
// fetch has been passed over MAX_WAIT times in a row.
module mem_arbiter_prio
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   grant_en,
  output owner_e win
);

  localparam int CW = $clog2(MAX_WAIT + 2);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wcnt_d, wcnt_q;
  logic          starved;

  always_comb begin
    starved = i_req && (wcnt_q == WAIT_MAX);
    win     = (d_req && !starved) ? OWN_D : OWN_I;
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (!i_req) begin
      wcnt_d = '0;
    end else if (grant_en) begin
      if (win == OWN_I) begin
        wcnt_d = '0;
      end else if (wcnt_q != WAIT_MAX) begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Arbitrates an instruction-fetch port and a load/store port onto one synchronous
// memory, one access at a time, with registered memory-side outputs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_busy,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          arb_ready
);

  state_e        state_d, state_q;
  owner_e        owner_d, owner_q;
  owner_e        win;
  logic          store_d, store_q;
  logic          grant_en;
  logic          i_gnt_d, i_gnt_q, d_gnt_d, d_gnt_q;
  logic          i_rvalid_d, i_rvalid_q, d_rvalid_d, d_rvalid_q;
  logic [DW-1:0] i_rdata_d, i_rdata_q, d_rdata_d, d_rdata_q;
  logic [AW-1:0] m_addr_d, m_addr_q;
  logic          m_we_d, m_we_q;
  logic [DW-1:0] m_wdata_d, m_wdata_q;

  assign grant_en = (state_q == ST_IDLE) && !mem_busy && (i_req || d_req);

  mem_arbiter_prio #(
    .MAX_WAIT (MAX_WAIT)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .d_req    (d_req),
    .grant_en (grant_en),
    .win      (win)
  );

  // Memory-side outputs and grants are only non-zero for the single ACCESS cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    store_d    = store_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    m_addr_d   = '0;
    m_we_d     = 1'b0;
    m_wdata_d  = '0;
    case (state_q)
      ST_INIT: begin
        if (!mem_busy) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (mem_busy) begin
          state_d = ST_INIT;
        end else if (grant_en) begin
          owner_d = win;
          state_d = ST_ACCESS;
          if (win == OWN_D) begin
            d_gnt_d   = 1'b1;
            m_addr_d  = d_addr;
            m_we_d    = d_we;
            m_wdata_d = d_we ? d_wdata : '0;
            store_d   = d_we;
          end else begin
            i_gnt_d  = 1'b1;
            m_addr_d = i_addr;
            store_d  = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (store_q) begin
          state_d = mem_busy ? ST_INIT : ST_IDLE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (owner_q == OWN_I) begin
          i_rdata_d  = m_rdata;
          i_rvalid_d = 1'b1;
        end else begin
          d_rdata_d  = m_rdata;
          d_rvalid_d = 1'b1;
        end
        state_d = mem_busy ? ST_INIT : ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      owner_q    <= OWN_I;
      store_q    <= 1'b0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      m_addr_q   <= '0;
      m_we_q     <= 1'b0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      store_q    <= store_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      m_addr_q   <= m_addr_d;
      m_we_q     <= m_we_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign m_addr    = m_addr_q;
  assign m_we      = m_we_q;
  assign m_wdata   = m_wdata_q;
  assign arb_ready = (state_q != ST_INIT);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// checked by a grant/response scoreboard against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW       = 16;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_busy = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, m_we, arb_ready;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;

  logic [DW-1:0] mem     [64];
  logic [DW-1:0] ref_mem [64];

  typedef struct {
    logic [DW-1:0] data;
    longint        due;
  } rd_exp_t;

  rd_exp_t iq[$];
  rd_exp_t dq[$];
  int      wcnt    = 0;
  logic    prev_we = 1'b0;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_busy  (mem_busy),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .m_addr    (m_addr),
    .m_we      (m_we),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .arb_ready (arb_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Synchronous memory: address sampled at the edge, data valid the following cycle.
  always @(posedge clk) begin
    logic [DW-1:0] rd;
    rd = mem[m_addr[5:0]];
    if (m_we) mem[m_addr[5:0]] = m_wdata;
    m_rdata <= rd;
  end

  // Monitor / scoreboard
  always @(posedge clk) begin
    rd_exp_t e;
    logic    exp_d;
    cyc++;
    #1;
    if (!rst) begin
      iq.delete();
      dq.delete();
      wcnt    = 0;
      prev_we = 1'b0;
    end else begin
      chk("dual_gnt", 64'(i_gnt & d_gnt), 64'(0));
      chk("m_we_one_cycle", 64'(m_we & prev_we), 64'(0));
      chk("m_we_with_gnt", 64'(m_we & ~d_gnt), 64'(0));
      prev_we = m_we;
      if (i_gnt || d_gnt) begin
        exp_d = d_req && !(i_req && wcnt == MAX_WAIT);
        chk("gnt_has_req", 64'(i_req | d_req), 64'(1));
        chk("gnt_winner", 64'({i_gnt, d_gnt}), exp_d ? 64'(1) : 64'(2));
        if (d_gnt) begin
          if (i_req && wcnt < MAX_WAIT) wcnt++;
          chk("d_m_addr", 64'(m_addr), 64'(d_addr));
          chk("d_m_we", 64'(m_we), 64'(d_we));
          if (d_we) begin
            chk("d_m_wdata", 64'(m_wdata), 64'(d_wdata));
            ref_mem[d_addr[5:0]] = d_wdata;
          end else begin
            e.data = ref_mem[d_addr[5:0]];
            e.due  = cyc + 2;
            dq.push_back(e);
          end
        end else begin
          wcnt = 0;
          chk("i_m_addr", 64'(m_addr), 64'(i_addr));
          chk("i_m_we", 64'(m_we), 64'(0));
          e.data = ref_mem[i_addr[5:0]];
          e.due  = cyc + 2;
          iq.push_back(e);
        end
      end
      if (!i_req) wcnt = 0;

      if (i_rvalid) begin
        if (iq.size() == 0) chk("i_rvalid_unexpected", 64'(1), 64'(0));
        else begin
          e = iq.pop_front();
          chk("i_rdata", 64'(i_rdata), 64'(e.data));
          chk("i_rvalid_latency", 64'(cyc), 64'(e.due));
        end
      end
      if (iq.size() > 0 && cyc > iq[0].due) begin
        chk("i_rvalid_timeout", 64'(cyc), 64'(iq[0].due));
        void'(iq.pop_front());
      end
      if (d_rvalid) begin
        if (dq.size() == 0) chk("d_rvalid_unexpected", 64'(1), 64'(0));
        else begin
          e = dq.pop_front();
          chk("d_rdata", 64'(d_rdata), 64'(e.data));
          chk("d_rvalid_latency", 64'(cyc), 64'(e.due));
        end
      end
      if (dq.size() > 0 && cyc > dq[0].due) begin
        chk("d_rvalid_timeout", 64'(cyc), 64'(dq[0].due));
        void'(dq.pop_front());
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  kg, kv, nwe, nrv, ngt, ng, guard, busy_cnt;
    bit  seq[16];

    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4]     = 32'h2008_0005;
    ref_mem[4] = 32'h2008_0005;

    repeat (3) tick();
    chk("rst_ctrl_outputs", 64'({arb_ready, i_gnt, d_gnt, i_rvalid, d_rvalid, m_we}), 64'(0));
    chk("rst_m_addr", 64'(m_addr), 64'(0));
    chk("rst_m_wdata", 64'(m_wdata), 64'(0));
    chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));

    // Release reset while memory is still filling; a pending load must wait.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 16'h0008;
    rst    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("busy_arb_ready", 64'(arb_ready), 64'(0));
      chk("busy_no_gnt", 64'(i_gnt | d_gnt), 64'(0));
    end
    mem_busy = 1'b0;
    tick();
    chk("ready_after_busy", 64'(arb_ready), 64'(1));
    chk("no_gnt_leaving_init", 64'(d_gnt), 64'(0));
    tick();
    chk("first_load_gnt", 64'(d_gnt), 64'(1));
    d_req = 1'b0;
    repeat (4) tick();

    // Single fetch
    i_req  = 1'b1;
    i_addr = 16'h0004;
    kg = -1;
    kv = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (i_gnt) begin
        kg    = k;
        i_req = 1'b0;
      end
      if (i_rvalid) kv = k;
    end
    chk("fetch_gnt_cycle", 64'(kg), 64'(1));
    chk("fetch_rvalid_cycle", 64'(kv), 64'(3));
    chk("fetch_rdata", 64'(i_rdata), 64'(32'h2008_0005));

    // Single store
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h0010;
    d_wdata = 32'hDEAD_BEEF;
    nwe = 0;
    nrv = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (d_gnt) d_req = 1'b0;
      if (m_we) begin
        nwe++;
        chk("store_m_addr", 64'(m_addr), 64'(16'h0010));
        chk("store_m_wdata", 64'(m_wdata), 64'(32'hDEAD_BEEF));
      end
      if (d_rvalid) nrv++;
    end
    chk("store_we_cycles", 64'(nwe), 64'(1));
    chk("store_no_rvalid", 64'(nrv), 64'(0));
    chk("store_mem", 64'(mem[16]), 64'(32'hDEAD_BEEF));
    d_we = 1'b0;

    // Both ports held: data wins MAX_WAIT times, then the fetch.
    i_addr = 16'h0014;
    d_addr = 16'h0018;
    i_req  = 1'b1;
    d_req  = 1'b1;
    ng     = 0;
    guard  = 0;
    while (ng < 15 && guard < 200) begin
      tick();
      guard++;
      if (d_gnt && ng < 16) begin
        seq[ng] = 1'b0;
        ng++;
      end
      if (i_gnt && ng < 16) begin
        seq[ng] = 1'b1;
        ng++;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("starve_grant_count", 64'(ng), 64'(15));
    for (int n = 0; n < 15; n++) begin
      chk("starve_pattern", 64'(seq[n]), 64'((n % 5) == 4));
    end
    repeat (4) tick();

    // Memory goes busy while a load is in ACCESS.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 16'h0008;
    tick();
    chk("busy_load_gnt", 64'(d_gnt), 64'(1));
    d_req    = 1'b0;
    mem_busy = 1'b1;
    i_req    = 1'b1;
    i_addr   = 16'h0004;
    nrv = 0;
    ngt = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (d_rvalid) begin
        nrv++;
        chk("busy_load_rdata", 64'(d_rdata), 64'(ref_mem[8]));
      end
      ngt += int'(i_gnt | d_gnt);
    end
    chk("busy_load_rvalid", 64'(nrv), 64'(1));
    chk("busy_after_no_gnt", 64'(ngt), 64'(0));
    chk("busy_after_not_ready", 64'(arb_ready), 64'(0));
    mem_busy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (i_gnt) i_req = 1'b0;
    end
    chk("fetch_after_busy", 64'(i_req), 64'(0));
    repeat (3) tick();

    // Reset asserted while a load sits in CAPTURE.
    d_req  = 1'b1;
    d_addr = 16'h000C;
    tick();
    chk("cap_load_gnt", 64'(d_gnt), 64'(1));
    d_req = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_cap_ctrl", 64'({arb_ready, i_gnt, d_gnt, i_rvalid, d_rvalid, m_we}), 64'(0));
    chk("rst_cap_m_addr", 64'(m_addr), 64'(0));
    chk("rst_cap_rdata", 64'({i_rdata, d_rdata}), 64'(0));
    nrv = 0;
    repeat (3) begin
      tick();
      nrv += int'(d_rvalid | i_rvalid);
    end
    chk("rst_cap_no_rvalid", 64'(nrv), 64'(0));
    rst = 1'b1;
    repeat (2) tick();

    // Randomized traffic with occasional memory-busy windows.
    busy_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (i_gnt) i_req = 1'b0;
      if (d_gnt) d_req = 1'b0;
      if (!i_req && $urandom_range(0, 99) < 40) begin
        i_req  = 1'b1;
        i_addr = AW'($urandom_range(0, 63));
      end
      if (!d_req && $urandom_range(0, 99) < 50) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = AW'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
      if (busy_cnt > 0) busy_cnt--;
      else if ($urandom_range(0, 99) < 2) busy_cnt = $urandom_range(1, 6);
      mem_busy = (busy_cnt > 0);
    end
    mem_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (i_gnt) i_req = 1'b0;
      if (d_gnt) d_req = 1'b0;
    end
    chk("drain_reqs", 64'({i_req, d_req}), 64'(0));
    chk("drain_iq", 64'(iq.size()), 64'(0));
    chk("drain_dq", 64'(dq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
